// File: rtl/switch_pkg.sv
// Shared definitions for the slide-switch conditioning path and the decoder stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package switch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } deb_state_t;

    localparam int SW_WIDTH         = 8;
    localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage : switch_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing asynchronous pins into the clk domain.
// Latency: 2 cycles from d to q.
// Backpressure: none, free-running sampler.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule : sync_2ff

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the switch bank as one vector; pulses on each commit.
// Latency: DEBOUNCE_CYCLES+3 cycles from a pin change to sw_stable.
// Backpressure: none; a pattern that stops holding is dropped or retimed.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             sw_changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s2;

    deb_state_t       state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_d;
    logic             changed_d;
    logic [WIDTH-1:0] mask_d;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (s2)
    );

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = sw_stable;
        changed_d = 1'b0;
        mask_d    = '0;

        case (state_q)
            IDLE: begin
                if (s2 != sw_stable) begin
                    cand_d  = s2;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (s2 == cand_q) begin
                    // Compare before incrementing so the counter never wraps.
                    if (cnt_q == CNT_LAST) begin
                        stable_d  = cand_q;
                        changed_d = 1'b1;
                        mask_d    = cand_q ^ sw_stable;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (s2 == sw_stable) begin
                    state_d = IDLE;
                end else begin
                    // Any other pattern restarts timing against the new candidate.
                    cand_d = s2;
                    cnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            cnt_q        <= '0;
            sw_stable    <= '0;
            sw_changed   <= 1'b0;
            changed_mask <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            sw_stable    <= stable_d;
            sw_changed   <= changed_d;
            changed_mask <= mask_d;
        end
    end

    assign busy = (state_q == COUNT);

endmodule : switch_debouncer
